alu_ctrl_seq: RTL

//  Sequencing initiator for the 32-bit combinational ALU. Accepts an op (ALUOp/funct + operands)

---
 rtl/alu_ctrl_seq.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// alu_ctrl_seq
//   Sequencing initiator for the 32-bit combinational ALU. An op (ALUOp/funct
//   plus two operands) is accepted from decode over a valid/ready handshake.
//   The operands and the decoded 4-bit ctrl code are registered and held
//   stable on the ALU inputs. Single-cycle ops are held for one cycle and mult
//   for MULT_LAT cycles. The ALU result and zero flag are then captured and
//   offered to the consumer over a second valid/ready handshake.
//
// Parameters
//   MULT_LAT      cycles the ALU inputs are held for mult before capture (>=1)
//
// Configuration macro
//   ALU_CTRL_ILLEGAL_TRAP_EN
//     defined   : an undecodable funct skips the ALU (ctrl stays 4'hF) and
//                 completes straight away with result_o=0, zero_o=1 and
//                 illegal_o=1.
//     undefined : an undecodable funct executes as add (ctrl 2) and
//                 illegal_o is tied 0.
//
// Ports
//   clk_i         in   1   clock, rising edge
//   rst_i         in   1   synchronous reset, active-low
//   valid_i       in   1   op request valid
//   ready_o       out  1   op accepted when valid_i & ready_o (IDLE only)
//   aluop_i       in   3   op class from main decoder
//   funct_i       in   6   R-type funct field
//   src1_i        in   32  operand 1
//   src2_i        in   32  operand 2
//   alu_ctrl_o    out  4   ALU ctrl code (4'hF = NOP outside EXEC/MWAIT)
//   alu_src1_o    out  32  registered ALU operand 1
//   alu_src2_o    out  32  registered ALU operand 2
//   alu_result_i  in   32  ALU result
//   alu_zero_i    in   1   ALU zero flag
//   valid_o       out  1   result valid (DONE)
//   ready_i       in   1   consumer ready
//   result_o      out  32  captured result
//   zero_o        out  1   captured zero flag
//   illegal_o     out  1   undecodable op flag, qualified by valid_o
// -----------------------------------------------------------------------------
module alu_ctrl_seq #(
  parameter int MULT_LAT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [2:0]  aluop_i,
  input  logic [5:0]  funct_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  output logic [3:0]  alu_ctrl_o,
  output logic [31:0] alu_src1_o,
  output logic [31:0] alu_src2_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_zero_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic        zero_o,
  output logic        illegal_o
);

  localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  localparam logic [3:0] CTRL_AND  = 4'h0;
  localparam logic [3:0] CTRL_OR   = 4'h1;
  localparam logic [3:0] CTRL_ADD  = 4'h2;
  localparam logic [3:0] CTRL_BNEQ = 4'h3;
  localparam logic [3:0] CTRL_BGE  = 4'h4;
  localparam logic [3:0] CTRL_BGT  = 4'h5;
  localparam logic [3:0] CTRL_SUB  = 4'h6;
  localparam logic [3:0] CTRL_SLT  = 4'h7;
  localparam logic [3:0] CTRL_MULT = 4'h8;
  localparam logic [3:0] CTRL_NOP  = 4'hF;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  // NOP doubles as the "illegal" marker out of the decoder; it is never a
  // legitimate decode result, so it cannot be confused with a real op.
  localparam logic [3:0] CTRL_BAD = CTRL_NOP;
`else
  localparam logic [3:0] CTRL_BAD = CTRL_ADD;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_MWAIT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [3:0]         ctrl_q,  ctrl_d;
  logic [31:0]        src1_q,  src1_d;
  logic [31:0]        src2_q,  src2_d;
  logic [31:0]        result_q, result_d;
  logic               zero_q,  zero_d;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic               illegal_q, illegal_d;
`endif

  logic [3:0]         dec_ctrl;

  // ALUOp/funct -> ALU ctrl code.
  function automatic logic [3:0] decode_ctrl(input logic [2:0] op,
                                             input logic [5:0] fn);
    logic [3:0] c;
    c = CTRL_ADD;
    case (op)
      3'b000: c = CTRL_ADD;
      3'b001: c = CTRL_SUB;
      3'b011: c = CTRL_BNEQ;
      3'b100: c = CTRL_BGE;
      3'b101: c = CTRL_BGT;
      3'b110: c = CTRL_OR;
      3'b111: c = CTRL_SLT;
      3'b010: begin
        case (fn)
          6'b100000: c = CTRL_ADD;
          6'b100010: c = CTRL_SUB;
          6'b100100: c = CTRL_AND;
          6'b100101: c = CTRL_OR;
          6'b101010: c = CTRL_SLT;
          6'b011000: c = CTRL_MULT;
          default:   c = CTRL_BAD;
        endcase
      end
      default: c = CTRL_ADD;
    endcase
    return c;
  endfunction

  assign dec_ctrl = decode_ctrl(aluop_i, funct_i);

  // State and datapath registers. Everything, data included, returns to a
  // known value on reset so an in-flight op leaves no trace.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ctrl_q    <= CTRL_NOP;
      src1_q    <= '0;
      src2_q    <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    result_d  = result_q;
    zero_d    = zero_q;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          src1_d = src1_i;
          src2_d = src2_i;
          ctrl_d = dec_ctrl;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
          illegal_d = 1'b0;
`endif
          if (dec_ctrl == CTRL_MULT) begin
            state_d = S_MWAIT;
            cnt_d   = CNT_W'(MULT_LAT - 1);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
          end else if (dec_ctrl == CTRL_BAD) begin
            // Trap: the ALU is never driven, the canned result is loaded here.
            state_d   = S_DONE;
            result_d  = '0;
            zero_d    = 1'b1;
            illegal_d = 1'b1;
`endif
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        result_d = alu_result_i;
        zero_d   = alu_zero_i;
        state_d  = S_DONE;
      end
      S_MWAIT: begin
        if (cnt_q == '0) begin
          result_d = alu_result_i;
          zero_d   = alu_zero_i;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        // No accept here even when ready_i is high; IDLE takes the next op.
        if (ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    ready_o    = (state_q == S_IDLE);
    valid_o    = (state_q == S_DONE);
    alu_ctrl_o = CTRL_NOP;
    if (state_q == S_EXEC || state_q == S_MWAIT) alu_ctrl_o = ctrl_q;
  end

  assign alu_src1_o = src1_q;
  assign alu_src2_o = src2_q;
  assign result_o   = result_q;
  assign zero_o     = zero_q;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  assign illegal_o  = illegal_q;
`else
  assign illegal_o  = 1'b0;
`endif

endmodule
